// File: rtl/interp_pkg.sv
// Shared types for the span attribute interpolator.
//   state_e : span FSM states
//   rnd_e   : rounding modes applied when reducing the accumulator to output precision
//   acc_w() : accumulator width (input width plus integer guard bits)
//   to_rnd(): maps the raw 2-bit command field onto rnd_e (code 3 falls back to truncate)
package interp_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      RND_TRUNC   = 2'd0,
      RND_HALF_UP = 2'd1,
      RND_RNE     = 2'd2
   } rnd_e;

   function automatic int unsigned acc_w(input int unsigned width, input int unsigned guard);
      return width + guard;
   endfunction

   function automatic rnd_e to_rnd(input logic [1:0] raw);
      rnd_e r;
      case (raw)
         2'd1:    r = RND_HALF_UP;
         2'd2:    r = RND_RNE;
         default: r = RND_TRUNC;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/interp_round_sat.sv
// Combinational shift / round / saturate of one accumulator channel.
//   acc_i : signed accumulator value, Sh fraction bits above the output format
//   rnd_i : rounding mode
//   val_o : signed result, clamped to the OutW-bit range
//   sat_o : high when val_o was clamped
module interp_round_sat
   import interp_pkg::*;
#(
   parameter int unsigned AccW = 36,
   parameter int unsigned OutW = 16,
   parameter int unsigned Sh   = 16
) (
   input  logic [AccW-1:0] acc_i,
   input  rnd_e            rnd_i,
   output logic [OutW-1:0] val_o,
   output logic            sat_o
);

   localparam int unsigned HalfSh = (Sh == 0) ? 0 : Sh - 1;
   localparam logic [AccW:0] Half   = (Sh == 0) ? '0 : ((AccW + 1)'(1) << HalfSh);
   localparam logic [AccW:0] HalfM1 = (Sh == 0) ? '0 : Half - (AccW + 1)'(1);
   localparam logic signed [AccW:0] MaxV = {{(AccW - OutW + 2){1'b0}}, {(OutW - 1){1'b1}}};
   localparam logic signed [AccW:0] MinV = {{(AccW - OutW + 2){1'b1}}, {(OutW - 1){1'b0}}};

   logic        [AccW:0] bias;
   logic signed [AccW:0] sum;
   logic signed [AccW:0] shifted;

   always_comb begin
      bias = '0;
      if (Sh != 0) begin
         case (rnd_i)
            RND_HALF_UP: bias = Half;
            // Ties go up only when the surviving LSB is odd.
            RND_RNE:     bias = HalfM1 + {{AccW{1'b0}}, acc_i[Sh]};
            default:     bias = '0;
         endcase
      end
   end

   // One extra bit so the rounding add can never overflow.
   assign sum     = $signed({acc_i[AccW-1], acc_i}) + $signed(bias);
   assign shifted = sum >>> Sh;

   always_comb begin
      sat_o = 1'b0;
      val_o = shifted[OutW-1:0];
      if (shifted > MaxV) begin
         sat_o = 1'b1;
         val_o = MaxV[OutW-1:0];
      end else if (shifted < MinV) begin
         sat_o = 1'b1;
         val_o = MinV[OutW-1:0];
      end
   end

endmodule

// File: rtl/attr_span_interp.sv
// Multi-channel incremental attribute interpolator.
// Accepts one span command (per-channel start/gradient, length, rounding mode) and
// streams one rounded/saturated pixel per cycle with valid/ready backpressure.
//   clk, rst          : clock, asynchronous active-high reset
//   cmd_*_i / cmd_ready_o : span command handshake and payload
//   flush_i           : synchronous abort of the current span
//   pix_*_o / pix_ready_i : pixel stream (data, per-channel saturation, last flag)
module attr_span_interp
   import interp_pkg::*;
#(
   parameter int unsigned CH       = 4,
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned FRAC     = 16,
   parameter int unsigned GUARD    = 4,
   parameter int unsigned OUT_W    = 16,
   parameter int unsigned OUT_FRAC = 0,
   parameter int unsigned LEN_W    = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic [CH*WIDTH-1:0]   cmd_init_i,
   input  logic [CH*WIDTH-1:0]   cmd_grad_i,
   input  logic [LEN_W-1:0]      cmd_len_i,
   input  logic [1:0]            cmd_rnd_i,
   input  logic                  flush_i,
   output logic                  pix_valid_o,
   input  logic                  pix_ready_i,
   output logic [CH*OUT_W-1:0]   pix_data_o,
   output logic [CH-1:0]         pix_sat_o,
   output logic                  pix_last_o
);

   localparam int unsigned AccW = acc_w(WIDTH, GUARD);
   localparam int unsigned Sh   = FRAC - OUT_FRAC;

   state_e                state_q;
   logic [AccW-1:0]       acc_q  [CH];
   logic [AccW-1:0]       grad_q [CH];
   logic [LEN_W-1:0]      cnt_q;
   rnd_e                  rnd_q;
   logic [CH*OUT_W-1:0]   data_q;
   logic [CH-1:0]         sat_q;
   logic                  last_q;

   rnd_e                  cmd_rnd;
   rnd_e                  rs_mode;
   logic [AccW-1:0]       init_x [CH];
   logic [AccW-1:0]       grad_x [CH];
   logic [AccW-1:0]       rs_in  [CH];
   logic [OUT_W-1:0]      rs_val [CH];
   logic [CH-1:0]         rs_sat;

   assign cmd_rnd = to_rnd(cmd_rnd_i);
   // In IDLE the rounders see the incoming start values; in RUN the live accumulators.
   assign rs_mode = (state_q == IDLE) ? cmd_rnd : rnd_q;

   for (genvar c = 0; c < CH; c++) begin : g_ch
      assign init_x[c] = {{GUARD{cmd_init_i[c*WIDTH+WIDTH-1]}}, cmd_init_i[c*WIDTH +: WIDTH]};
      assign grad_x[c] = {{GUARD{cmd_grad_i[c*WIDTH+WIDTH-1]}}, cmd_grad_i[c*WIDTH +: WIDTH]};
      assign rs_in[c]  = (state_q == IDLE) ? init_x[c] : acc_q[c];

      interp_round_sat #(
         .AccW (AccW),
         .OutW (OUT_W),
         .Sh   (Sh)
      ) u_rs (
         .acc_i (rs_in[c]),
         .rnd_i (rs_mode),
         .val_o (rs_val[c]),
         .sat_o (rs_sat[c])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rnd_q   <= RND_TRUNC;
         data_q  <= '0;
         sat_q   <= '0;
         last_q  <= 1'b0;
         for (int c = 0; c < CH; c++) begin
            acc_q[c]  <= '0;
            grad_q[c] <= '0;
         end
      end else if (flush_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         last_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid_i && (cmd_len_i != '0)) begin
                  state_q <= RUN;
                  cnt_q   <= cmd_len_i - LEN_W'(1);
                  last_q  <= (cmd_len_i == LEN_W'(1));
                  rnd_q   <= cmd_rnd;
                  sat_q   <= rs_sat;
                  for (int c = 0; c < CH; c++) begin
                     data_q[c*OUT_W +: OUT_W] <= rs_val[c];
                     acc_q[c]                 <= init_x[c] + grad_x[c];
                     grad_q[c]                <= grad_x[c];
                  end
               end
            end
            RUN: begin
               if (pix_ready_i) begin
                  if (cnt_q == '0) begin
                     state_q <= IDLE;
                  end else begin
                     cnt_q  <= cnt_q - LEN_W'(1);
                     last_q <= (cnt_q == LEN_W'(1));
                     sat_q  <= rs_sat;
                     for (int c = 0; c < CH; c++) begin
                        data_q[c*OUT_W +: OUT_W] <= rs_val[c];
                        acc_q[c]                 <= acc_q[c] + grad_q[c];
                     end
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd_ready_o = (state_q == IDLE);
   assign pix_valid_o = (state_q == RUN);
   assign pix_data_o  = data_q;
   assign pix_sat_o   = sat_q;
   assign pix_last_o  = last_q;

endmodule

// File: tb/tb_attr_span_interp.sv
// Directed bench for attr_span_interp with a reference-model scoreboard.
module tb_attr_span_interp;

   localparam int CH    = 4;
   localparam int WIDTH = 32;
   localparam int OUT_W = 8;
   localparam int LEN_W = 12;

   typedef struct packed {
      logic [CH*OUT_W-1:0] data;
      logic [CH-1:0]       sat;
      logic                last;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                cmd_valid = 1'b0;
   logic                cmd_ready;
   logic [CH*WIDTH-1:0] cmd_init = '0;
   logic [CH*WIDTH-1:0] cmd_grad = '0;
   logic [LEN_W-1:0]    cmd_len = '0;
   logic [1:0]          cmd_rnd = '0;
   logic                flush = 1'b0;
   logic                pix_valid;
   logic                pix_ready = 1'b1;
   logic [CH*OUT_W-1:0] pix_data;
   logic [CH-1:0]       pix_sat;
   logic                pix_last;

   int   checks = 0;
   int   errors = 0;
   int   hs_cnt = 0;
   bit   rand_ready = 1'b0;
   int   t_init [CH];
   int   t_grad [CH];
   exp_t sb [$];

   attr_span_interp #(
      .CH       (CH),
      .WIDTH    (WIDTH),
      .FRAC     (16),
      .GUARD    (4),
      .OUT_W    (OUT_W),
      .OUT_FRAC (0),
      .LEN_W    (LEN_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_init_i  (cmd_init),
      .cmd_grad_i  (cmd_grad),
      .cmd_len_i   (cmd_len),
      .cmd_rnd_i   (cmd_rnd),
      .flush_i     (flush),
      .pix_valid_o (pix_valid),
      .pix_ready_i (pix_ready),
      .pix_data_o  (pix_data),
      .pix_sat_o   (pix_sat),
      .pix_last_o  (pix_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: exact value init + k*grad in Q16, reduced by the chosen rounding rule.
   function automatic exp_t model(input int k, input int len, input int rnd);
      exp_t   e;
      longint v, q, rem;
      e.last = (k == len - 1);
      for (int c = 0; c < CH; c++) begin
         v   = longint'(t_init[c]) + longint'(k) * longint'(t_grad[c]);
         q   = v >>> 16;
         rem = v - (q * 65536);
         if (rnd == 1 && rem >= 32768) q = q + 1;
         if (rnd == 2 && (rem > 32768 || (rem == 32768 && (q & 1) == 1))) q = q + 1;
         e.sat[c] = 1'b0;
         if (q > 127) begin
            q = 127;
            e.sat[c] = 1'b1;
         end else if (q < -128) begin
            q = -128;
            e.sat[c] = 1'b1;
         end
         e.data[c*OUT_W +: OUT_W] = 8'(q);
      end
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      if (rand_ready) pix_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send(input int len, input int rnd);
      int n = 0;
      while (!cmd_ready && n < 200) begin
         step();
         n++;
      end
      chk("cmd_ready_wait", cmd_ready, 1'b1);
      for (int c = 0; c < CH; c++) begin
         cmd_init[c*WIDTH +: WIDTH] = t_init[c];
         cmd_grad[c*WIDTH +: WIDTH] = t_grad[c];
      end
      cmd_len   = LEN_W'(len);
      cmd_rnd   = 2'(rnd);
      cmd_valid = 1'b1;
      for (int k = 0; k < len; k++) sb.push_back(model(k, len, rnd));
      step();
      cmd_valid = 1'b0;
      chk("first_pix_latency", pix_valid, (len > 0));
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || pix_valid) && n < 300) begin
         step();
         n++;
      end
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      chk("drain_valid_low", pix_valid, 1'b0);
   endtask

   task automatic set_ch(input int c, input int ini, input int grd);
      t_init[c] = ini;
      t_grad[c] = grd;
   endtask

   // Scoreboard side: compares every transferred pixel, and the held pixel while stalled.
   always @(negedge clk) begin
      if (!rst && pix_valid) begin
         chk("cmd_ready_low_in_run", cmd_ready, 1'b0);
         if (sb.size() == 0) begin
            chk("unexpected_pixel", pix_valid, 1'b0);
         end else if (pix_ready && !flush) begin
            exp_t e;
            e = sb.pop_front();
            chk("pix_data", pix_data, e.data);
            chk("pix_sat", pix_sat, e.sat);
            chk("pix_last", pix_last, e.last);
            hs_cnt++;
         end else if (!pix_ready) begin
            chk("stall_hold_data", pix_data, sb[0].data);
            chk("stall_hold_last", pix_last, sb[0].last);
         end
      end
   end

   initial begin
      // Reset values
      #3;
      chk("rst_valid", pix_valid, 1'b0);
      chk("rst_data", pix_data, '0);
      step();
      step();
      rst = 1'b0;
      step();
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      chk("rst_sat", pix_sat, '0);
      chk("rst_last", pix_last, 1'b0);

      // Rounding modes: ch0 = 0.5 + k*1.0, other channels distinct patterns
      set_ch(0, 32'h0000_8000, 32'h0001_0000);
      set_ch(1, 32'h0001_8000, 32'h0000_8000);
      set_ch(2, -32'sh0000_8000, 32'h0002_8000);
      set_ch(3, 32'h0000_7FFF, -32'sh0000_4000);
      for (int m = 0; m < 4; m++) begin
         send(4, m);
         drain();
      end

      // Saturation, positive and negative
      set_ch(0, 126 * 65536, 65536);
      set_ch(1, -8355840, -65536);
      set_ch(2, 0, 40 * 65536);
      set_ch(3, -100 * 65536, -20 * 65536);
      send(4, 0);
      drain();
      send(3, 2);
      drain();

      // Backpressure
      set_ch(0, 32'h0003_4000, 32'h0001_C000);
      set_ch(1, -32'sh0005_0000, 32'h0000_C000);
      set_ch(2, 32'h0010_0000, -32'sh0003_0000);
      set_ch(3, 0, 32'h0000_1000);
      hs_cnt = 0;
      rand_ready = 1'b1;
      send(5, 1);
      drain();
      rand_ready = 1'b0;
      pix_ready = 1'b1;
      chk("bp_handshakes", 64'(hs_cnt), 64'd5);

      // Zero-length command
      send(0, 0);
      for (int i = 0; i < 3; i++) begin
         chk("len0_no_valid", pix_valid, 1'b0);
         chk("len0_ready", cmd_ready, 1'b1);
         step();
      end
      send(2, 2);
      drain();

      // Flush in the third cycle of a 10-pixel span
      send(10, 0);
      step();
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_valid_low", pix_valid, 1'b0);
      chk("flush_idle", cmd_ready, 1'b1);
      sb.delete();
      set_ch(0, 5 * 65536, -65536);
      send(3, 0);
      drain();

      // Asynchronous reset mid-span
      send(8, 1);
      step();
      #3;
      rst = 1'b1;
      #1;
      chk("arst_valid", pix_valid, 1'b0);
      chk("arst_data", pix_data, '0);
      chk("arst_sat", pix_sat, '0);
      chk("arst_last", pix_last, 1'b0);
      sb.delete();
      step();
      rst = 1'b0;
      step();
      chk("arst_cmd_ready", cmd_ready, 1'b1);

      // Independent per-channel gradients after reset
      set_ch(0, 10 * 65536, 3 * 65536);
      set_ch(1, -10 * 65536, -32'sh0001_8000);
      set_ch(2, 32'h0000_8000, 32'h0000_8000);
      set_ch(3, 50 * 65536, -7 * 65536);
      send(6, 2);
      drain();

      chk("sb_empty_end", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
